// File: rtl/regfile_mp_sb.sv
// Multi-read-port integer register file with two write ports and a per-register busy scoreboard.
// Latency: reads are combinational (zero cycles); writes and scoreboard updates land on the next rising edge.
// Backpressure: none; every port is accepted every cycle, and stalling is left to decode via rd_busy.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset (clears all data and busy bits)
//   rd_addr / rd_data     NRD packed read ports, port i at [i*AW +: AW] / [i*XLEN +: XLEN]
//   rd_busy               scoreboard bit of each read port's register
//   wa_*                  write port A (ALU writeback), never touches the scoreboard
//   wb_*                  write port B (load writeback), wins over A and clears the busy bit
//   sb_set_en/addr        mark a register busy when a load issues (wins over a same-cycle clear)
//   busy_cnt              population count of busy registers
//
// Optional build macro REGFILE_BYPASS_EN: forwards same-cycle write data (B over A) and
// same-cycle port-B busy clears to the read ports. Undefined by default.
module regfile_mp_sb #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wa_en,
  input  logic [AW-1:0]       wa_addr,
  input  logic [XLEN-1:0]     wa_data,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                sb_set_en,
  input  logic [AW-1:0]       sb_set_addr,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;
  logic [AW-1:0]    ra;

  // Entry 0 is reset and then never written, so it stays hard zero and never busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        mem[r] <= '0;
      end
      busy <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        // Port B is the load path and takes the register on an address collision.
        if (wb_en && wb_addr == AW'(r)) begin
          mem[r] <= wb_data;
        end else if (wa_en && wa_addr == AW'(r)) begin
          mem[r] <= wa_data;
        end
        // A new load issuing to a register must not be lost to the retiring load's clear.
        if (sb_set_en && sb_set_addr == AW'(r)) begin
          busy[r] <= 1'b1;
        end else if (wb_en && wb_addr == AW'(r)) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int p = 0; p < NRD; p++) begin
      ra = rd_addr[p*AW +: AW];
      if (ra != '0) begin
        rd_data[p*XLEN +: XLEN] = mem[ra];
        rd_busy[p]              = busy[ra];
`ifdef REGFILE_BYPASS_EN
        // Forwarding is suppressed while in reset so the outputs read as cleared state.
        if (!rst) begin
          if (wb_en && wb_addr == ra) begin
            rd_data[p*XLEN +: XLEN] = wb_data;
            if (!(sb_set_en && sb_set_addr == ra)) begin
              rd_busy[p] = 1'b0;
            end
          end else if (wa_en && wa_addr == ra) begin
            rd_data[p*XLEN +: XLEN] = wa_data;
          end
        end
`endif
      end
    end
  end

  always_comb begin
    busy_cnt = '0;
    for (int r = 0; r < NREGS; r++) begin
      busy_cnt = busy_cnt + {{AW{1'b0}}, busy[r]};
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, AW = 5;
  localparam int WX = 64, WN = 16, WR = 4, WA = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wa_en, wb_en, sb_set_en;
  logic [AW-1:0]       wa_addr, wb_addr, sb_set_addr;
  logic [XLEN-1:0]     wa_data, wb_data;
  logic [AW:0]         busy_cnt;

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy_cnt(busy_cnt)
  );

  logic [WR*WA-1:0] w_rd_addr;
  logic [WR*WX-1:0] w_rd_data;
  logic [WR-1:0]    w_rd_busy;
  logic             w_wa_en, w_wb_en, w_sb_set_en;
  logic [WA-1:0]    w_wa_addr, w_wb_addr, w_sb_set_addr;
  logic [WX-1:0]    w_wa_data, w_wb_data;
  logic [WA:0]      w_busy_cnt;

  regfile_mp_sb #(.XLEN(WX), .NREGS(WN), .NRD(WR)) dut_w (
    .clk(clk), .rst(rst), .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
    .wa_en(w_wa_en), .wa_addr(w_wa_addr), .wa_data(w_wa_data),
    .wb_en(w_wb_en), .wb_addr(w_wb_addr), .wb_data(w_wb_data),
    .sb_set_en(w_sb_set_en), .sb_set_addr(w_sb_set_addr), .busy_cnt(w_busy_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference state for the default-size instance.
  logic [XLEN-1:0] mreg [NREGS];
  logic            mbusy [NREGS];

  typedef struct {
    int          port;
    int          addr;
    logic [31:0] data;
    logic        bsy;
    string       nm;
  } exp_t;
  exp_t sbq[$];

  task automatic mdl_reset();
    for (int i = 0; i < NREGS; i++) begin
      mreg[i]  = '0;
      mbusy[i] = 1'b0;
    end
  endtask

  // Applies the inputs present at a rising edge to the reference state.
  task automatic mdl_step();
    if (wa_en && wa_addr != 0) mreg[wa_addr] = wa_data;
    if (wb_en && wb_addr != 0) mreg[wb_addr] = wb_data;
    if (wb_en && wb_addr != 0) mbusy[wb_addr] = 1'b0;
    if (sb_set_en && sb_set_addr != 0) mbusy[sb_set_addr] = 1'b1;
  endtask

  function automatic int mdl_cnt();
    int c = 0;
    for (int i = 0; i < NREGS; i++) c += int'(mbusy[i]);
    return c;
  endfunction

  // Drives a read address and queues what that port must show this cycle.
  task automatic push_read(input int port, input int addr, input string nm);
    exp_t e;
    logic [AW-1:0] a;
    a = addr[AW-1:0];
    rd_addr[port*AW +: AW] = a;
    e.port = port;
    e.addr = addr;
    e.nm   = nm;
    e.data = (addr == 0) ? 32'h0 : mreg[a];
    e.bsy  = (addr == 0) ? 1'b0 : mbusy[a];
`ifdef REGFILE_BYPASS_EN
    if (addr != 0 && !rst) begin
      if (wb_en && wb_addr == a) begin
        e.data = wb_data;
        if (!(sb_set_en && sb_set_addr == a)) e.bsy = 1'b0;
      end else if (wa_en && wa_addr == a) begin
        e.data = wa_data;
      end
    end
`endif
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [AW:0] exp_cnt;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (rd_data[e.port*XLEN +: XLEN] !== e.data) begin
        errors++;
        $display("FAIL %s data port%0d x%0d got %h expected %h", e.nm, e.port, e.addr,
                 rd_data[e.port*XLEN +: XLEN], e.data);
      end
      checks++;
      if (rd_busy[e.port] !== e.bsy) begin
        errors++;
        $display("FAIL %s busy port%0d x%0d got %b expected %b", e.nm, e.port, e.addr,
                 rd_busy[e.port], e.bsy);
      end
    end
    exp_cnt = (AW+1)'(mdl_cnt());
    checks++;
    if (busy_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL busy_cnt got %0d expected %0d", busy_cnt, exp_cnt);
    end
  endtask

  // Compare queued reads at the falling edge, then clock the pending writes.
  task automatic step();
    @(negedge clk);
    drain();
    @(posedge clk);
    if (!rst) mdl_step();
    #1;
    wa_en = 1'b0;
    wb_en = 1'b0;
    sb_set_en = 1'b0;
  endtask

  task automatic test_reset();
    mdl_reset();
    for (int a = 0; a < NREGS; a++) begin
      push_read(0, a, "reset_rd0");
      push_read(1, NREGS-1-a, "reset_rd1");
      #2;
      drain();
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hDEADBEEF;
    push_read(0, 0, "x0_write_same");
    step();
    push_read(0, 0, "x0_after_write");
    push_read(1, 0, "x0_after_write");
    step();
  endtask

  task automatic test_same_addr();
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h12345678;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hCAFEBABE;
    push_read(0, 5, "collide_same");
    push_read(1, 5, "collide_same");
    step();
    push_read(0, 5, "collide_next");
    push_read(1, 5, "collide_next");
    step();
    wa_en = 1'b1; wa_addr = 5'd10; wa_data = 32'h0A0A0A0A;
    wb_en = 1'b1; wb_addr = 5'd11; wb_data = 32'h0B0B0B0B;
    step();
    push_read(0, 10, "dual_a");
    push_read(1, 11, "dual_b");
    step();
  endtask

  task automatic test_scoreboard();
    sb_set_en = 1'b1; sb_set_addr = 5'd7;
    step();
    push_read(0, 7, "sb_set7");
    push_read(1, 9, "sb_set7");
    step();
    sb_set_en = 1'b1; sb_set_addr = 5'd9;
    step();
    push_read(0, 7, "sb_set9");
    push_read(1, 9, "sb_set9");
    step();
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h70;
    step();
    push_read(0, 7, "sb_porta_keeps");
    step();
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h71;
    step();
    push_read(0, 7, "sb_portb_clears");
    push_read(1, 9, "sb_portb_clears");
    step();
    sb_set_en = 1'b1; sb_set_addr = 5'd9;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    step();
    push_read(0, 9, "sb_set_wins");
    step();
  endtask

  task automatic test_bypass();
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h11;
    sb_set_en = 1'b1; sb_set_addr = 5'd3;
    step();
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h55;
    push_read(0, 3, "byp_same_cycle");
    push_read(1, 3, "byp_same_cycle");
    step();
    push_read(0, 3, "byp_next_cycle");
    step();
  endtask

  task automatic test_async_reset();
    wa_en = 1'b1; wa_addr = 5'd31; wa_data = 32'hA5A5A5A5;
    sb_set_en = 1'b1; sb_set_addr = 5'd31;
    step();
    push_read(0, 31, "x31_before_rst");
    step();
    #2;
    rst = 1'b1;
    mdl_reset();
    #1;
    push_read(0, 31, "x31_async_rst");
    push_read(1, 5, "x5_async_rst");
    drain();
    // An edge while reset is held must drop the write and the set.
    wa_en = 1'b1; wa_addr = 5'd6; wa_data = 32'h77;
    sb_set_en = 1'b1; sb_set_addr = 5'd6;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb_set_en = 1'b0;
    wa_addr = 5'd4; wa_data = 32'h44;
    @(posedge clk);
    mdl_step();
    #1;
    wa_en = 1'b0;
    push_read(0, 6, "write_under_rst");
    push_read(1, 4, "first_edge_after_rst");
    step();
  endtask

  function automatic logic [WX-1:0] wval(input int i);
    return {32'h1000_0000 + 32'(i), 32'hF0F0_0000 ^ (32'(i) * 32'h1111)};
  endfunction

  task automatic test_wide();
    logic [WX-1:0] wm [WN];
    logic [WX-1:0] wq[$];
    logic [WX-1:0] ev;
    int raddr [WR];
    raddr[0] = 1; raddr[1] = 8; raddr[2] = 15; raddr[3] = 0;
    for (int i = 0; i < WN; i++) wm[i] = '0;
    for (int i = 1; i < WN; i++) begin
      if (i % 2 == 1) begin
        w_wa_en = 1'b1; w_wa_addr = WA'(i); w_wa_data = wval(i);
      end else begin
        w_wb_en = 1'b1; w_wb_addr = WA'(i); w_wb_data = wval(i);
      end
      @(posedge clk);
      wm[i] = wval(i);
      #1;
      w_wa_en = 1'b0;
      w_wb_en = 1'b0;
    end
    for (int p = 0; p < WR; p++) begin
      w_rd_addr[p*WA +: WA] = WA'(raddr[p]);
      wq.push_back(wm[raddr[p]]);
    end
    @(negedge clk);
    for (int p = 0; p < WR; p++) begin
      ev = wq.pop_front();
      checks++;
      if (w_rd_data[p*WX +: WX] !== ev) begin
        errors++;
        $display("FAIL wide_read port%0d x%0d got %h expected %h", p, raddr[p],
                 w_rd_data[p*WX +: WX], ev);
      end
    end
    checks++;
    if (w_rd_busy !== 4'b0000 || w_busy_cnt !== 5'd0) begin
      errors++;
      $display("FAIL wide_busy got busy %b cnt %0d expected 0000 0", w_rd_busy, w_busy_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    wa_en = 1'b0; wa_addr = '0; wa_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    sb_set_en = 1'b0; sb_set_addr = '0;
    w_rd_addr = '0;
    w_wa_en = 1'b0; w_wa_addr = '0; w_wa_data = '0;
    w_wb_en = 1'b0; w_wb_addr = '0; w_wb_data = '0;
    w_sb_set_en = 1'b0; w_sb_set_addr = '0;
    test_reset();
    test_same_addr();
    test_scoreboard();
    test_bypass();
    test_async_reset();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
